// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory and gates core reset
//
// Packs an 8-bit valid/ready stream little-endian into 32-bit words and writes them to
// consecutive word addresses of instruction memory. The core is held in reset until the
// requested number of words has been written.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start, len      begin a load of len words (legal range 1..2**ADDR_W)
//   in_data/valid   byte stream input, in_ready when a byte can be taken
//   imem_we/addr/wd instruction memory write port (byte address, word data)
//   core_rst        core reset, released only in DONE
//   busy, done      loading / load complete
//   err             sticky flag: the most recent start carried an illegal len

module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wd,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_next;
    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] len_q;
    logic [31:0]     word;

    logic            len_ok;
    logic            start_seen;
    logic            last_word;

    assign len_ok     = (len != '0) && (len <= MAX_LEN);
    // start is only honoured while no load is in flight
    assign start_seen = start && ((state == IDLE) || (state == DONE));
    // word_cnt never exceeds len_q-1 here, so the increment cannot overflow
    assign last_word  = (word_cnt + ONE) == len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        core_rst   = 1'b1;
        case (state)
            IDLE: begin
                if (start && len_ok) state_next = RECV;
            end
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (byte_cnt == 2'd3)) state_next = WRITE;
            end
            WRITE: begin
                imem_we    = 1'b1;
                busy       = 1'b1;
                state_next = last_word ? DONE : RECV;
            end
            DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
                if (start && len_ok) state_next = RECV;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            word     <= '0;
            err      <= 1'b0;
        end else begin
            if (start_seen) begin
                if (len_ok) begin
                    len_q    <= len;
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    err      <= 1'b0;
                end else begin
                    err      <= 1'b1;
                end
            end
            if ((state == RECV) && in_valid) begin
                word[{byte_cnt, 3'b000} +: 8] <= in_data;
                // wraps 3 -> 0 on the fourth byte of a word
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == WRITE) begin
                word_cnt <= word_cnt + ONE;
            end
        end
    end

    assign imem_addr = {{(32 - ADDR_W - 3){1'b0}}, word_cnt, 2'b00};
    assign imem_wd   = word;

endmodule
